// File: rtl/wishbone_ctrl_sequencer.sv
// Wishbone classic initiator: one command in flight, registered bus and
// response outputs, optional ack timeout, sticky spurious-ack flag.
module wishbone_ctrl_sequencer #(
    parameter int pAdrBits = 4,
    parameter int pDatBits = 8,
    parameter int pTimeout = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [pAdrBits-1:0] cmd_adr,
    input  logic [pDatBits-1:0] cmd_dat,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [pDatBits-1:0] rsp_dat,
    output logic                rsp_err,
    output logic                spurious,
    output logic                wb_c_stb,
    output logic                wb_c_we,
    output logic [pAdrBits-1:0] wb_c_adr,
    output logic [pDatBits-1:0] wb_c_dat,
    input  logic                wb_p_ack,
    input  logic [pDatBits-1:0] wb_p_dat
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // pTimeout=0 still needs a 1-bit counter so the declarations stay legal
    localparam int CW = (pTimeout > 0) ? $clog2(pTimeout + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (pTimeout > 0) ? CW'(pTimeout - 1) : '0;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                stb_q, stb_d;
    logic                we_q, we_d;
    logic [pAdrBits-1:0] adr_q, adr_d;
    logic [pDatBits-1:0] dat_q, dat_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [pDatBits-1:0] rsp_dat_q, rsp_dat_d;
    logic                rsp_err_q, rsp_err_d;
    logic                spurious_q, spurious_d;
    logic                timeout_hit;

    assign cmd_ready   = (state_q == IDLE);
    assign timeout_hit = (pTimeout != 0) && (cnt_q == LIMIT);

    // Next-state logic for the IDLE -> REQ -> RESP sequence
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        // stb is high exactly while in REQ, so an ack elsewhere is unsolicited
        spurious_d  = spurious_q | (wb_p_ack && (state_q != REQ));
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    stb_d   = 1'b1;
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // ack takes priority over a timeout landing in the same cycle
                if (wb_p_ack) begin
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? '0 : wb_p_dat;
                    state_d     = RESP;
                end else if (timeout_hit) begin
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    state_d     = RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            spurious_q  <= spurious_d;
        end
    end

    assign wb_c_stb  = stb_q;
    assign wb_c_we   = we_q;
    assign wb_c_adr  = adr_q;
    assign wb_c_dat  = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign spurious  = spurious_q;

endmodule
